// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM-subset processor.
// Sequences the datapath through a 10-state Moore FSM, decodes ALUControl,
// holds the NZCV flags and gates register/memory/PC writes on the condition field.
// Ports:
//   clk, reset                     clock, async active-high reset
//   Cond, Op, Funct                instruction register fields
//   ALUFlags                       {N,Z,C,V} from the ALU
//   PCWrite, MemWrite, IRWrite,
//   RegWrite                       write enables (forced low while reset is high)
//   AdrSrc, ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl            datapath selects (registered Moore decodes)
//   ImmSrc, RegSrc                 direct decodes of Op
//   State                          current state code, for debug
module multicycle_controller #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    typedef struct packed {
        logic       nextpc;
        logic       adrsrc;
        logic       memw;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       aluop;
        logic       regw;
        logic       branch;
    } moore_t;

    state_t     state_q, state_d;
    logic [3:0] flags;
    logic       condexreg, condexreg_d, condex;
    logic       pcwrite_q, irwrite_q, memwrite_q, regwrite_q;
    logic [3:0] cmd;
    logic [1:0] dec_alucontrol, flagw;
    logic       dec_nowrite, arith, exec, nowrite_d;
    moore_t     m;

    // Raw Moore outputs of a state; anything not set is 0.
    function automatic moore_t moore(input state_t s);
        moore_t o;
        o = '0;
        case (s)
            FETCH:  begin o.irwrite = 1'b1; o.nextpc = 1'b1; o.alusrca = 1'b1;
                          o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
            DECODE: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
            MEMADR: o.alusrcb = 2'b01;
            MEMRD:  o.adrsrc = 1'b1;
            MEMWR:  begin o.adrsrc = 1'b1; o.memw = 1'b1; end
            MEMWB:  begin o.resultsrc = 2'b01; o.regw = 1'b1; end
            EXECR:  o.aluop = 1'b1;
            EXECI:  begin o.alusrcb = 2'b01; o.aluop = 1'b1; end
            ALUWB:  o.regw = 1'b1;
            BRANCH: begin o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.branch = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Condition field evaluated against stored {N,Z,C,V}.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return ~z;
            4'b0010: return cf;
            4'b0011: return ~cf;
            4'b0100: return n;
            4'b0101: return ~n;
            4'b0110: return v;
            4'b0111: return ~v;
            4'b1000: return cf & ~z;
            4'b1001: return ~cf | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return ~z & (n == v);
            4'b1101: return z | (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU decode, next state and the gating terms for the next cycle's outputs.
    always_comb begin
        cmd            = Funct[4:1];
        dec_alucontrol = 2'b00;
        dec_nowrite    = 1'b1;
        case (cmd)
            4'b0100: begin dec_alucontrol = 2'b00; dec_nowrite = 1'b0; end
            4'b0010: begin dec_alucontrol = 2'b01; dec_nowrite = 1'b0; end
            4'b0000: begin dec_alucontrol = 2'b10; dec_nowrite = 1'b0; end
            4'b1100: begin dec_alucontrol = 2'b11; dec_nowrite = 1'b0; end
            4'b1010: begin dec_alucontrol = 2'b01; dec_nowrite = 1'b1; end
            default: begin dec_alucontrol = 2'b00; dec_nowrite = 1'b1; end
        endcase
        arith  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        flagw  = {Funct[0], Funct[0] & arith};
        condex = cond_check(Cond, flags);
        exec   = (state_q == EXECR) || (state_q == EXECI);

        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: case (Op)
                        2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase

        // The condition result is frozen when leaving DECODE so later flag
        // updates cannot affect this instruction's own writes.
        condexreg_d = (state_q == DECODE) ? condex : condexreg;
        // NoWrite only matters for the ALUWB that follows an EXEC state.
        nowrite_d   = exec & dec_nowrite;
        m           = moore(state_d);
    end

    // State, flags and registered outputs; outputs are computed for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            flags      <= FLAGS_RESET;
            condexreg  <= 1'b0;
            pcwrite_q  <= 1'b1;
            irwrite_q  <= 1'b1;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            AdrSrc     <= 1'b0;
            ResultSrc  <= 2'b10;
            ALUSrcA    <= 1'b1;
            ALUSrcB    <= 2'b10;
            ALUControl <= 2'b00;
        end else begin
            state_q   <= state_d;
            condexreg <= condexreg_d;
            if (exec && condexreg && flagw[1]) flags[3:2] <= ALUFlags[3:2];
            if (exec && condexreg && flagw[0]) flags[1:0] <= ALUFlags[1:0];
            pcwrite_q  <= m.nextpc | (m.branch & condexreg_d);
            irwrite_q  <= m.irwrite;
            memwrite_q <= m.memw & condexreg_d;
            regwrite_q <= m.regw & condexreg_d & ~nowrite_d;
            AdrSrc     <= m.adrsrc;
            ResultSrc  <= m.resultsrc;
            ALUSrcA    <= m.alusrca;
            ALUSrcB    <= m.alusrcb;
            ALUControl <= m.aluop ? dec_alucontrol : 2'b00;
        end
    end

    // Enables hold FETCH values through reset so the first edge after release
    // fetches; the reset gate keeps them low while reset is high.
    assign PCWrite  = pcwrite_q & ~reset;
    assign IRWrite  = irwrite_q & ~reset;
    assign MemWrite = memwrite_q & ~reset;
    assign RegWrite = regwrite_q & ~reset;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a
// random instruction stream against an instruction-level reference model.
module tb_multicycle_controller;

    localparam logic [3:0] FLAGS_RESET = 4'b0100;

    logic       clk, reset;
    logic [3:0] Cond, ALUFlags, State;
    logic [1:0] Op, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [5:0] Funct;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] mflags;

    multicycle_controller #(.FLAGS_RESET(FLAGS_RESET)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            0: return z;            1: return !z;
            2: return cf;           3: return !cf;
            4: return n;            5: return !n;
            6: return v;            7: return !v;
            8: return cf && !z;     9: return !cf || z;
            10: return n == v;      11: return n != v;
            12: return !z && n == v; 13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_ctl(input logic [3:0] cmd);
        case (cmd)
            4'd2: return 2'd1;  4'd0: return 2'd2;  4'd12: return 2'd3;
            4'd10: return 2'd1; default: return 2'd0;
        endcase
    endfunction

    function automatic bit writes_reg(input logic [3:0] cmd);
        return cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12;
    endfunction

    // Expected {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite}.
    function automatic logic [11:0] exp_vec(input int st, input logic [3:0] cmd, input bit pass);
        bit pcw, adr, mw, irw, sa, rw;
        bit [1:0] rs, sb, ac;
        {pcw, adr, mw, irw, sa, rw, rs, sb, ac} = '0;
        case (st)
            0: begin irw = 1; pcw = 1; sa = 1; sb = 2; rs = 2; end
            1: begin sa = 1; sb = 2; rs = 2; end
            2: sb = 1;
            3: adr = 1;
            4: begin rs = 1; rw = pass; end
            5: begin adr = 1; mw = pass; end
            6: ac = alu_ctl(cmd);
            7: begin sb = 1; ac = alu_ctl(cmd); end
            8: rw = pass && writes_reg(cmd);
            9: begin sb = 1; rs = 2; pcw = pass; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, ac, rw};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, RegWrite};
    endfunction

    // One full instruction, entered at a negedge while the DUT is in FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input bit force_f, input logic [3:0] fval);
        int path[$];
        bit pass;
        logic [3:0] af, cmd;
        logic [11:0] e;
        cmd = f[4:1];
        Cond = c; Op = op; Funct = f;
        case (op)
            2'b00: path = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
            2'b01: path = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10: path = '{0, 1, 9};
            default: path = '{0, 1};
        endcase
        pass = cond_ok(c, mflags);
        foreach (path[k]) begin
            af = force_f ? fval : 4'($urandom);
            ALUFlags = af;
            #1;
            n_cmp++;
            if (State !== 4'(path[k])) begin
                n_err++;
                $display("FAIL state: got %0d exp %0d (cond %h op %b funct %b)", State, path[k], c, op, f);
            end
            e = exp_vec(path[k], cmd, pass);
            n_cmp++;
            if (obs_vec() !== e) begin
                n_err++;
                $display("FAIL outputs in state %0d: got %h exp %h (cond %h op %b funct %b flags %b)",
                         path[k], obs_vec(), e, c, op, f, mflags);
            end
            n_cmp++;
            if ({ImmSrc, RegSrc} !== {op, op == 2'b01, op == 2'b10}) begin
                n_err++;
                $display("FAIL immsrc/regsrc: got %b exp %b", {ImmSrc, RegSrc}, {op, op == 2'b01, op == 2'b10});
            end
            if ((path[k] == 6 || path[k] == 7) && pass && f[0]) begin
                mflags[3:2] = af[3:2];
                if (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd10) mflags[1:0] = af[1:0];
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [11:0] e;
        e = exp_vec(0, 4'd0, 1'b0) & ~12'hB01;
        n_cmp++;
        if (State !== 4'd0 || obs_vec() !== e) begin
            n_err++;
            $display("FAIL %s: state %0d outputs %h exp state 0 outputs %h", tag, State, obs_vec(), e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = '0; ALUFlags = '0;
        @(negedge clk); @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        mflags = FLAGS_RESET;
    endtask

    task automatic test_add();
        run_instr(4'hE, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
        run_instr(4'hE, 2'b00, {1'b1, 4'b1100, 1'b0}, 1'b0, 4'h0);
    endtask

    task automatic test_ldr();
        run_instr(4'hE, 2'b01, 6'b011001, 1'b0, 4'h0);
    endtask

    task automatic test_str_eq();
        run_instr(4'hE, 2'b00, {1'b0, 4'b1010, 1'b1}, 1'b1, 4'b0000);
        run_instr(4'h0, 2'b01, 6'b011000, 1'b0, 4'h0);
    endtask

    task automatic test_cmp();
        run_instr(4'hE, 2'b00, {1'b0, 4'b1010, 1'b1}, 1'b1, 4'b0110);
        run_instr(4'h0, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
        run_instr(4'h2, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
        run_instr(4'h6, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
    endtask

    task automatic test_subs_ne();
        run_instr(4'hE, 2'b00, {1'b0, 4'b1010, 1'b1}, 1'b1, 4'b0000);
        run_instr(4'h1, 2'b00, {1'b0, 4'b0010, 1'b1}, 1'b1, 4'b0100);
        run_instr(4'h0, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
    endtask

    task automatic test_branch();
        run_instr(4'hE, 2'b10, 6'($urandom), 1'b0, 4'h0);
        run_instr(4'hF, 2'b10, 6'($urandom), 1'b0, 4'h0);
        run_instr(4'hE, 2'b11, 6'($urandom), 1'b0, 4'h0);
    endtask

    task automatic test_reset_mid();
        int exp_st[3] = '{0, 1, 2};
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; ALUFlags = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (State !== 4'(exp_st[k])) begin
                n_err++;
                $display("FAIL mid-reset path: got %0d exp %0d", State, exp_st[k]);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (State !== 4'd5 || MemWrite !== 1'b1) begin
            n_err++;
            $display("FAIL memwr before reset: state %0d memwrite %b exp 5 1", State, MemWrite);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (State !== 4'd0 || {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            n_err++;
            $display("FAIL async reset: state %0d enables %b exp 0 0000", State,
                     {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        @(negedge clk); #1;
        check_reset_outputs("reset held");
        @(negedge clk);
        reset = 1'b0;
        mflags = FLAGS_RESET;
        run_instr(4'h0, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
        run_instr(4'h1, 2'b00, {1'b0, 4'b0100, 1'b0}, 1'b0, 4'h0);
    endtask

    task automatic test_random();
        logic [3:0] cmds[6] = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10, 4'd7};
        logic [5:0] f;
        for (int i = 0; i < 400; i++) begin
            f = 6'($urandom);
            if ($urandom_range(0, 1) == 0) f[4:1] = cmds[$urandom_range(0, 5)];
            run_instr(4'($urandom), 2'($urandom), f, 1'b0, 4'h0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr();
        test_str_eq();
        test_cmp();
        test_subs_ne();
        test_branch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
